alu_instr_encoder: RTL and testbench
====================================

ALU_INSTR_ENCODER -- requirements
Module: alu_instr_encoder

Interface
REQ-001 Parameter ALUCONTROL_WIDTH, default 6, width of the ALU operation code.
REQ-002 Parameter ADDR_WIDTH, default 10, byte-address width of out_addr.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  encode request present.
REQ-006 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-007 req_code  input  ALUCONTROL_WIDTH  ALU operation code, same encoding as the ALU decoder's ALUControl output.
REQ-008 req_use_imm  input  1  0 = R-type, 1 = I-type.
REQ-009 req_rd, req_rs1, req_rs2  input  5 each  register indices.
REQ-010 req_imm  input  12  I-type immediate; bits [4:0] are the shamt for shifts.
REQ-011 out_valid  output  1  encoded instruction available.
REQ-012 out_ready  input  1  consumer accepts the instruction.
REQ-013 out_instr  output  32  RV32 instruction word.
REQ-014 out_addr  output  ADDR_WIDTH  byte address for the instruction-memory write.
REQ-015 err_pulse  output  1  one-cycle pulse on an illegal request.
REQ-016 err_code  output  ALUCONTROL_WIDTH  code of the last illegal request.
REQ-017 instr_count  output  16  count of completed output handshakes.

Function
REQ-018 Legal codes SHALL encode as follows (code: funct3/funct7):
- ADD 0x00: 000/0000000
- SUB 0x01: 000/0100000, R only
- AND 0x02: 111
- OR 0x03: 110
- XOR 0x04: 100
- SLT 0x05: 010
- SLL 0x06: 001/0000000
- SRA 0x07: 101/0100000
- SRL 0x0B: 101/0000000
- SLTU 0x0C: 011
- All other codes are illegal.
REQ-019 R-type SHALL be {funct7, rs2, rs1, funct3, rd, 0110011}, with funct7 = 0000000 wherever the table above gives none.
REQ-020 I-type SHALL be {imm12, rs1, funct3, rd, 0010011}:
- SLL/SRL/SRA: imm12 = {funct7, req_imm[4:0]}.
- All other legal codes: imm12 = req_imm.
REQ-021 SUB with req_use_imm=1 SHALL be illegal.
REQ-022 FSM states:
- IDLE: out_valid=0.
- VALID: out_valid=1; out_instr and out_addr are held stable until the output handshake.
REQ-023 req_ready SHALL equal (state==IDLE) OR out_ready.
REQ-024 Accepting a legal request SHALL register out_instr and move to VALID the next cycle (latency 1).
REQ-025 Accepting an illegal request SHALL:
- assert err_pulse for exactly the next cycle;
- latch err_code;
- make the next state IDLE;
- leave out_addr and instr_count unchanged.
REQ-026 On an output handshake (out_valid & out_ready):
- out_addr increments by 4, modulo 2^ADDR_WIDTH;
- instr_count increments, saturating at 0xFFFF.
REQ-027 An output handshake and a request acceptance in the same cycle SHALL both take effect: a legal request keeps VALID with the new word at the incremented address; an illegal one goes to IDLE and pulses err_pulse; sustained throughput 1 per cycle.
REQ-028 out_addr[1:0] SHALL always be 0.

Reset
REQ-029 On rst, the next edge SHALL set:
- state = IDLE;
- out_valid=0, out_instr=0, out_addr=0;
- err_pulse=0, err_code=0, instr_count=0.
REQ-030 A reset while in VALID SHALL discard the pending word with no handshake counted.

Structure
REQ-031 ALU code constants, the funct3/funct7 constants and the opcodes 0110011/0010011 SHALL live in a shared package, also used by the ALU decoder.
REQ-032 The combinational encode and legality check SHALL be the sub-module alu_enc_core; the FSM, address counter and instruction counter stay in alu_instr_encoder.

Verification
REQ-033 After reset: ADD, R-type, rd=1 rs1=2 rs2=3 -> out_instr 0x003100B3, out_addr 0, instr_count 1 after the handshake.
REQ-034 SUB, R-type, rd=5 rs1=6 rs2=7 -> 0x407302B3; SRA, I-type, rd=1 rs1=1 imm=3 -> 0x4030D093.
REQ-035 SUB with req_use_imm=1 -> err_pulse high one cycle, err_code 0x01, out_valid stays 0, instr_count unchanged.
REQ-036 Backpressure and streaming:
- out_ready low for 5 cycles in VALID -> out_instr/out_addr stable, req_ready 0.
- Three back-to-back ADDIs with out_ready=1 -> one word per cycle, addresses 0, 4, 8.
REQ-037 Address wrap: ADDR_WIDTH=4, five handshakes -> addresses 0, 4, 8, 12, 0.
REQ-038 Reset mid-VALID -> out_valid 0 and out_addr 0 on the next cycle; the pending word is never counted.

Source files
------------

// File: rtl/alu_instr_encoder_pkg.sv
// rtl/alu_instr_encoder_pkg.sv - ALU operation codes, RV32 field constants and field lookup
//
// Shared by the ALU decoder and the instruction encoder. The operation codes
// use the ALUControl encoding that the decoder produces.
package alu_instr_encoder_pkg;

  localparam int ALU_CODE_W = 6;

  typedef logic [ALU_CODE_W-1:0] alu_code_t;

  localparam alu_code_t ALU_ADD  = 6'h00;
  localparam alu_code_t ALU_SUB  = 6'h01;
  localparam alu_code_t ALU_AND  = 6'h02;
  localparam alu_code_t ALU_OR   = 6'h03;
  localparam alu_code_t ALU_XOR  = 6'h04;
  localparam alu_code_t ALU_SLT  = 6'h05;
  localparam alu_code_t ALU_SLL  = 6'h06;
  localparam alu_code_t ALU_SRA  = 6'h07;
  localparam alu_code_t ALU_SRL  = 6'h0B;
  localparam alu_code_t ALU_SLTU = 6'h0C;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // known:  code appears in the table at all
  // shift:  I-type form carries funct7 in imm[11:5] and shamt in imm[4:0]
  // r_only: no I-type form exists
  typedef struct packed {
    logic       known;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       shift;
    logic       r_only;
  } alu_fields_t;

  function automatic alu_fields_t alu_fields(input alu_code_t code);
    alu_fields_t f;
    f.known  = 1'b1;
    f.funct3 = F3_ADD_SUB;
    f.funct7 = F7_BASE;
    f.shift  = 1'b0;
    f.r_only = 1'b0;
    case (code)
      ALU_ADD:  f.funct3 = F3_ADD_SUB;
      ALU_SUB:  begin f.funct7 = F7_ALT; f.r_only = 1'b1; end
      ALU_AND:  f.funct3 = F3_AND;
      ALU_OR:   f.funct3 = F3_OR;
      ALU_XOR:  f.funct3 = F3_XOR;
      ALU_SLT:  f.funct3 = F3_SLT;
      ALU_SLL:  begin f.funct3 = F3_SLL; f.shift = 1'b1; end
      ALU_SRA:  begin f.funct3 = F3_SRL_SRA; f.funct7 = F7_ALT; f.shift = 1'b1; end
      ALU_SRL:  begin f.funct3 = F3_SRL_SRA; f.shift = 1'b1; end
      ALU_SLTU: f.funct3 = F3_SLTU;
      default:  f.known = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_instr_encoder_if.sv
// rtl/alu_instr_encoder_if.sv - request/output/status bundle of the instruction encoder
//
// master: producer of requests and consumer of encoded words (drives req_*, out_ready)
// slave:  the encoder (drives req_ready, out_*, err_*, instr_count)
interface alu_instr_encoder_if #(
  parameter int ALUCONTROL_WIDTH = 6,
  parameter int ADDR_WIDTH       = 10
);

  logic                        req_valid;
  logic                        req_ready;
  logic [ALUCONTROL_WIDTH-1:0] req_code;
  logic                        req_use_imm;
  logic [4:0]                  req_rd;
  logic [4:0]                  req_rs1;
  logic [4:0]                  req_rs2;
  logic [11:0]                 req_imm;

  logic                        out_valid;
  logic                        out_ready;
  logic [31:0]                 out_instr;
  logic [ADDR_WIDTH-1:0]       out_addr;

  logic                        err_pulse;
  logic [ALUCONTROL_WIDTH-1:0] err_code;
  logic [15:0]                 instr_count;

  modport master (
    output req_valid, req_code, req_use_imm, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    input  req_ready, out_valid, out_instr, out_addr, err_pulse, err_code, instr_count
  );

  modport slave (
    input  req_valid, req_code, req_use_imm, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    output req_ready, out_valid, out_instr, out_addr, err_pulse, err_code, instr_count
  );

endinterface

// File: rtl/alu_enc_core.sv
// rtl/alu_enc_core.sv - combinational RV32 OP/OP-IMM encode and legality check
//
// Ports:
//   code     in  ALU operation code (ALUControl encoding)
//   use_imm  in  0 = R-type, 1 = I-type
//   rd/rs1/rs2 in register indices
//   imm      in  I-type immediate, imm[4:0] is the shamt for shifts
//   instr    out encoded word (meaningful only when legal)
//   legal    out code is in the table and the requested form exists
module alu_enc_core
  import alu_instr_encoder_pkg::*;
#(
  parameter int ALUCONTROL_WIDTH = 6
) (
  input  logic [ALUCONTROL_WIDTH-1:0] code,
  input  logic                        use_imm,
  input  logic [4:0]                  rd,
  input  logic [4:0]                  rs1,
  input  logic [4:0]                  rs2,
  input  logic [11:0]                 imm,
  output logic [31:0]                 instr,
  output logic                        legal
);

  // Widen the code so that any bits above the table's width can be checked
  // for zero regardless of how ALUCONTROL_WIDTH compares to ALU_CODE_W.
  localparam int EXT_W = (ALUCONTROL_WIDTH > ALU_CODE_W) ? ALUCONTROL_WIDTH : ALU_CODE_W;

  logic [EXT_W-1:0] code_ext;
  logic             upper_zero;
  alu_fields_t      f;
  logic [11:0]      imm12;

  always_comb begin
    code_ext   = EXT_W'(code);
    upper_zero = ((code_ext >> ALU_CODE_W) == '0);
    f          = alu_fields(code_ext[ALU_CODE_W-1:0]);
    legal      = upper_zero & f.known & ~(f.r_only & use_imm);
    imm12      = f.shift ? {f.funct7, imm[4:0]} : imm;
    instr      = use_imm ? {imm12, rs1, f.funct3, rd, OPC_OP_IMM}
                         : {f.funct7, rs2, rs1, f.funct3, rd, OPC_OP};
  end

endmodule

// File: rtl/alu_instr_encoder.sv
// rtl/alu_instr_encoder.sv - ALU request to RV32 instruction-memory write stream
//
// Ports:
//   clk  in  clock, all state on the rising edge
//   rst  in  synchronous active-high reset
//   bus  slave modport of alu_instr_encoder_if:
//        req_*            encode request (valid/ready handshake)
//        out_valid/ready  encoded word handshake, out_instr/out_addr held while pending
//        err_pulse        one cycle after an illegal request is accepted
//        err_code         code of the last illegal request
//        instr_count      completed output handshakes, saturating
module alu_instr_encoder
  import alu_instr_encoder_pkg::*;
#(
  parameter int ALUCONTROL_WIDTH = 6,
  parameter int ADDR_WIDTH       = 10
) (
  input logic               clk,
  input logic               rst,
  alu_instr_encoder_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_VALID = 1'b1;

  logic [0:0]                  state;
  logic [31:0]                 instr_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic                        err_pulse_q;
  logic [ALUCONTROL_WIDTH-1:0] err_code_q;
  logic [15:0]                 count_q;

  logic [31:0] enc_instr;
  logic        enc_legal;
  logic        req_ready;
  logic        accept;
  logic        handshake;

  alu_enc_core #(
    .ALUCONTROL_WIDTH(ALUCONTROL_WIDTH)
  ) u_core (
    .code    (bus.req_code),
    .use_imm (bus.req_use_imm),
    .rd      (bus.req_rd),
    .rs1     (bus.req_rs1),
    .rs2     (bus.req_rs2),
    .imm     (bus.req_imm),
    .instr   (enc_instr),
    .legal   (enc_legal)
  );

  // A pending word being drained this cycle frees the slot, so a new request
  // can be taken in the same cycle for one-word-per-cycle streaming.
  assign req_ready = (state == S_IDLE) | bus.out_ready;
  assign accept    = bus.req_valid & req_ready;
  assign handshake = (state == S_VALID) & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      addr_q      <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
      count_q     <= '0;
    end else begin
      err_pulse_q <= 1'b0;

      // out_addr is the address of the word currently (or next) presented,
      // so it only advances once that word has been taken.
      if (handshake) begin
        addr_q <= addr_q + ADDR_WIDTH'(4);
        if (count_q != 16'hFFFF) begin
          count_q <= count_q + 16'd1;
        end
      end

      if (accept) begin
        if (enc_legal) begin
          state   <= S_VALID;
          instr_q <= enc_instr;
        end else begin
          state       <= S_IDLE;
          err_pulse_q <= 1'b1;
          err_code_q  <= bus.req_code;
        end
      end else if (handshake) begin
        state <= S_IDLE;
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.out_valid   = (state == S_VALID);
  assign bus.out_instr   = instr_q;
  assign bus.out_addr    = addr_q;
  assign bus.err_pulse   = err_pulse_q;
  assign bus.err_code    = err_code_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_alu_instr_encoder.sv
// tb/tb_alu_instr_encoder.sv - self-checking bench for alu_instr_encoder
module tb_alu_instr_encoder;

  logic clk = 1'b0;
  logic rst;
  logic rst_w;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_instr_encoder_if #(.ALUCONTROL_WIDTH(6), .ADDR_WIDTH(10)) bus ();
  alu_instr_encoder_if #(.ALUCONTROL_WIDTH(6), .ADDR_WIDTH(4))  bus_w ();

  alu_instr_encoder #(.ALUCONTROL_WIDTH(6), .ADDR_WIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_instr_encoder #(.ALUCONTROL_WIDTH(6), .ADDR_WIDTH(4)) dut_w (
    .clk (clk),
    .rst (rst_w),
    .bus (bus_w)
  );

  // Reference encoder straight from the instruction table: returns {legal, word}.
  function automatic logic [32:0] ref_enc(input int code, input bit use_imm, input int rd,
                                          input int rs1, input int rs2, input int imm);
    logic [31:0] f3, f7, imm12, w;
    bit shift, ok;
    f3 = 0; f7 = 0; shift = 0; ok = 1;
    case (code)
      0:  f3 = 0;
      1:  begin f3 = 0; f7 = 32; ok = !use_imm; end
      2:  f3 = 7;
      3:  f3 = 6;
      4:  f3 = 4;
      5:  f3 = 2;
      6:  begin f3 = 1; shift = 1; end
      7:  begin f3 = 5; f7 = 32; shift = 1; end
      11: begin f3 = 5; shift = 1; end
      12: f3 = 3;
      default: ok = 0;
    endcase
    if (use_imm) begin
      imm12 = shift ? (f7 * 32 + (imm % 32)) : imm;
      w = imm12 * 32'h100000 + rs1 * 32'h8000 + f3 * 32'h1000 + rd * 128 + 32'h13;
    end else begin
      w = f7 * 32'h2000000 + rs2 * 32'h100000 + rs1 * 32'h8000 + f3 * 32'h1000 + rd * 128 + 32'h33;
    end
    return {ok, w};
  endfunction

  task automatic set_req(input bit v, input int code, input bit use_imm, input int rd,
                         input int rs1, input int rs2, input int imm);
    bus.req_valid   = v;
    bus.req_code    = 6'(code);
    bus.req_use_imm = use_imm;
    bus.req_rd      = 5'(rd);
    bus.req_rs1     = 5'(rs1);
    bus.req_rs2     = 5'(rs2);
    bus.req_imm     = 12'(imm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(1, 0, 0, 1, 2, 3, 0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", bus.out_instr); end
    checks++; if (bus.out_addr !== 10'h0) begin failures++; $display("FAIL reset_out_addr got=%h exp=0", bus.out_addr); end
    checks++; if (bus.err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err_pulse got=%0b exp=0", bus.err_pulse); end
    checks++; if (bus.err_code !== 6'h0) begin failures++; $display("FAIL reset_err_code got=%h exp=0", bus.err_code); end
    checks++; if (bus.instr_count !== 16'h0) begin failures++; $display("FAIL reset_instr_count got=%0d exp=0", bus.instr_count); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", bus.req_ready); end
  endtask

  task automatic test_directed();
    do_reset();
    set_req(1, 0, 0, 1, 2, 3, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h003100B3) begin failures++; $display("FAIL add_instr got=%h exp=003100b3", bus.out_instr); end
    checks++; if (bus.out_addr !== 10'd0) begin failures++; $display("FAIL add_addr got=%0d exp=0", bus.out_addr); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.instr_count !== 16'd1) begin failures++; $display("FAIL add_count got=%0d exp=1", bus.instr_count); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_drained got=%0b exp=0", bus.out_valid); end
    set_req(1, 1, 0, 5, 6, 7, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.out_instr !== 32'h407302B3) begin failures++; $display("FAIL sub_instr got=%h exp=407302b3", bus.out_instr); end
    checks++; if (bus.out_addr !== 10'd4) begin failures++; $display("FAIL sub_addr got=%0d exp=4", bus.out_addr); end
    bus.out_ready = 1'b1;
    set_req(1, 7, 1, 1, 1, 0, 3);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL valid_ready_passthru got=%0b exp=1", bus.req_ready); end
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.out_instr !== 32'h4030D093) begin failures++; $display("FAIL sra_instr got=%h exp=4030d093", bus.out_instr); end
    checks++; if (bus.out_addr !== 10'd8) begin failures++; $display("FAIL sra_addr got=%0d exp=8", bus.out_addr); end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.instr_count !== 16'd3) begin failures++; $display("FAIL sra_count got=%0d exp=3", bus.instr_count); end
  endtask

  task automatic test_illegal();
    do_reset();
    set_req(1, 1, 1, 3, 4, 0, 9);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.err_pulse !== 1'b1) begin failures++; $display("FAIL subi_err_pulse got=%0b exp=1", bus.err_pulse); end
    checks++; if (bus.err_code !== 6'h01) begin failures++; $display("FAIL subi_err_code got=%h exp=01", bus.err_code); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL subi_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.instr_count !== 16'd0) begin failures++; $display("FAIL subi_count got=%0d exp=0", bus.instr_count); end
    tick();
    checks++; if (bus.err_pulse !== 1'b0) begin failures++; $display("FAIL subi_pulse_width got=%0b exp=0", bus.err_pulse); end
    checks++; if (bus.err_code !== 6'h01) begin failures++; $display("FAIL subi_code_held got=%h exp=01", bus.err_code); end
    set_req(1, 8, 0, 1, 1, 1, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.err_code !== 6'h08) begin failures++; $display("FAIL code8_err_code got=%h exp=08", bus.err_code); end
    checks++; if (bus.out_addr !== 10'd0) begin failures++; $display("FAIL illegal_addr got=%0d exp=0", bus.out_addr); end
  endtask

  task automatic test_backpressure();
    logic [32:0] r;
    do_reset();
    r = ref_enc(4, 1, 9, 10, 0, 12'h5A5);
    set_req(1, 4, 1, 9, 10, 0, 12'h5A5);
    tick();
    set_req(1, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready cyc=%0d got=%0b exp=0", i, bus.req_ready); end
      tick();
      checks++; if (bus.out_instr !== r[31:0] || bus.out_addr !== 10'd0 || bus.out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%h@%0d v=%0b exp=%h@0 v=1", i, bus.out_instr, bus.out_addr, bus.out_valid, r[31:0]);
      end
    end
    set_req(0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.instr_count !== 16'd1) begin failures++; $display("FAIL bp_count got=%0d exp=1", bus.instr_count); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] r;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r = ref_enc(0, 1, i + 1, 2, 0, i * 100 + 7);
      set_req(1, 0, 1, i + 1, 2, 0, i * 100 + 7);
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== r[31:0] || bus.out_addr !== 10'(i * 4)) begin
        failures++; $display("FAIL b2b_word i=%0d got=%h@%0d v=%0b exp=%h@%0d", i, bus.out_instr, bus.out_addr, bus.out_valid, r[31:0], i * 4);
      end
    end
    set_req(0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.instr_count !== 16'd3 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_count got=%0d v=%0b exp=3 v=0", bus.instr_count, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_valid();
    do_reset();
    set_req(1, 2, 0, 4, 5, 6, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 10'd0) begin
      failures++; $display("FAIL midrst_state got v=%0b addr=%0d exp v=0 addr=0", bus.out_valid, bus.out_addr);
    end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.instr_count !== 16'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", bus.instr_count); end
  endtask

  task automatic test_wrap();
    rst_w = 1'b1;
    bus_w.req_valid = 1'b0;
    bus_w.out_ready = 1'b0;
    tick();
    rst_w = 1'b0;
    bus_w.req_code = 6'd0; bus_w.req_use_imm = 1'b0;
    bus_w.req_rs1 = 5'd1; bus_w.req_rs2 = 5'd2; bus_w.req_imm = 12'd0;
    bus_w.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_w.req_valid = 1'b1;
      bus_w.req_rd    = 5'(i + 1);
      tick();
      checks++; if (bus_w.out_addr !== 4'((i * 4) % 16)) begin
        failures++; $display("FAIL wrap_addr i=%0d got=%0d exp=%0d", i, bus_w.out_addr, (i * 4) % 16);
      end
    end
    bus_w.req_valid = 1'b0;
    tick();
    bus_w.out_ready = 1'b0;
    checks++; if (bus_w.instr_count !== 16'd5) begin failures++; $display("FAIL wrap_count got=%0d exp=5", bus_w.instr_count); end
  endtask

  task automatic test_random();
    bit          m_valid, m_err_p, hs, acc, v, ui, ordy, exp_ready;
    logic [31:0] m_instr;
    int          m_addr, m_count, m_err_c, code, rd, rs1, rs2, imm;
    logic [32:0] r;
    do_reset();
    m_valid = 0; m_err_p = 0; m_instr = 0; m_addr = 0; m_count = 0; m_err_c = 0;
    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      code = $urandom_range(0, 15);
      ui   = $urandom_range(0, 1);
      rd   = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
      imm  = $urandom_range(0, 4095);
      ordy = ($urandom_range(0, 3) != 0);
      set_req(v, code, ui, rd, rs1, rs2, imm);
      bus.out_ready = ordy;
      #1;
      exp_ready = !m_valid || ordy;
      checks++; if (bus.req_ready !== exp_ready) begin failures++; $display("FAIL rnd_req_ready n=%0d got=%0b exp=%0b", n, bus.req_ready, exp_ready); end
      hs  = m_valid && ordy;
      acc = v && exp_ready;
      r   = ref_enc(code, ui, rd, rs1, rs2, imm);
      m_err_p = 0;
      if (hs) begin
        m_addr = (m_addr + 4) % 1024;
        if (m_count < 65535) m_count++;
      end
      if (acc) begin
        if (r[32]) begin m_valid = 1; m_instr = r[31:0]; end
        else begin m_valid = 0; m_err_p = 1; m_err_c = code; end
      end else if (hs) begin
        m_valid = 0;
      end
      tick();
      checks++; if (bus.out_valid !== m_valid || bus.out_addr !== 10'(m_addr) || bus.instr_count !== 16'(m_count)) begin
        failures++; $display("FAIL rnd_state n=%0d got v=%0b a=%0d c=%0d exp v=%0b a=%0d c=%0d", n, bus.out_valid, bus.out_addr, bus.instr_count, m_valid, m_addr, m_count);
      end
      checks++; if (bus.err_pulse !== m_err_p || bus.err_code !== 6'(m_err_c)) begin
        failures++; $display("FAIL rnd_err n=%0d got p=%0b c=%h exp p=%0b c=%h", n, bus.err_pulse, bus.err_code, m_err_p, m_err_c);
      end
      if (m_valid) begin
        checks++; if (bus.out_instr !== m_instr) begin failures++; $display("FAIL rnd_instr n=%0d got=%h exp=%h", n, bus.out_instr, m_instr); end
      end
    end
    set_req(0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    rst_w = 1'b1;
    bus_w.req_valid = 1'b0; bus_w.req_code = '0; bus_w.req_use_imm = 1'b0;
    bus_w.req_rd = '0; bus_w.req_rs1 = '0; bus_w.req_rs2 = '0; bus_w.req_imm = '0;
    bus_w.out_ready = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_valid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
